// File: rtl/decode_stage_pkg.sv
// Shared decode-stage types: op classes, RV32I major opcodes and the reset level.
package decode_stage_pkg;

    localparam logic RESET = 1'b0;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_ALU_I   = 4'd8,
        OP_ALU_R   = 4'd9,
        OP_SYSTEM  = 4'd10
    } op_class_t;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPCODE_ALU_R  = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_stage_decoder.sv
// Purely combinational RV32I field decoder: op class, register fields, usage flags, immediate.
module rv32i_decoder
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output op_class_t             op,
    output logic [9:0]            funct,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_used,
    output logic                  rs2_used,
    output logic                  rd_write,
    output logic [XLEN-1:0]       imm
);

    logic        writes_rd;
    logic [31:0] imm32;

    assign funct = {instr[31:25], instr[14:12]};
    assign rs1   = REG_ADDR_W'(instr[19:15]);
    assign rs2   = REG_ADDR_W'(instr[24:20]);

    // Branch and store encodings reuse bits 11:7 as immediate, so rd is only meaningful for writers.
    assign rd       = writes_rd ? REG_ADDR_W'(instr[11:7]) : '0;
    assign rd_write = writes_rd && (instr[11:7] != 5'd0);
    assign imm      = XLEN'($signed(imm32));

    always_comb begin
        op        = OP_ILLEGAL;
        writes_rd = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        imm32     = '0;
        case (instr[6:0])
            OPCODE_LUI: begin
                op        = OP_LUI;
                writes_rd = 1'b1;
                imm32     = {instr[31:12], 12'b0};
            end
            OPCODE_AUIPC: begin
                op        = OP_AUIPC;
                writes_rd = 1'b1;
                imm32     = {instr[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                op        = OP_JAL;
                writes_rd = 1'b1;
                imm32     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPCODE_JALR: begin
                op        = OP_JALR;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                imm32     = {{21{instr[31]}}, instr[30:20]};
            end
            OPCODE_BRANCH: begin
                op       = OP_BRANCH;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPCODE_LOAD: begin
                op        = OP_LOAD;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                imm32     = {{21{instr[31]}}, instr[30:20]};
            end
            OPCODE_STORE: begin
                op       = OP_STORE;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            end
            OPCODE_ALU_I: begin
                op        = OP_ALU_I;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                imm32     = {{21{instr[31]}}, instr[30:20]};
            end
            OPCODE_ALU_R: begin
                op        = OP_ALU_R;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            OPCODE_SYSTEM: begin
                op        = OP_SYSTEM;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                imm32     = {{21{instr[31]}}, instr[30:20]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand bypass, pending-write scoreboard, hazard stall and
// a registered valid/ready bundle towards execute.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic [REG_ADDR_W-1:0] rf_read1_id,
    output logic [REG_ADDR_W-1:0] rf_read2_id,
    input  logic [XLEN-1:0]       rf_read1_data,
    input  logic [XLEN-1:0]       rf_read2_data,
    input  logic                  wb_write_en,
    input  logic [REG_ADDR_W-1:0] wb_write_id,
    input  logic [XLEN-1:0]       wb_write_data,
    input  logic                  sb_release,
    input  logic [REG_ADDR_W-1:0] sb_release_id,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_pc,
    output op_class_t             ex_op,
    output logic [9:0]            ex_funct,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_rd_write
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    op_class_t             dec_op;
    logic [9:0]            dec_funct;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic                  dec_rs1_used;
    logic                  dec_rs2_used;
    logic                  dec_rd_write;
    logic [XLEN-1:0]       dec_imm;

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  wb_hit_rs1;
    logic                  wb_hit_rs2;
    logic                  wb_hit_rd;
    logic                  raw_stall;
    logic                  waw_stall;
    logic                  accept;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;

    rv32i_decoder #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decoder (
        .instr    (if_instr),
        .op       (dec_op),
        .funct    (dec_funct),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .rd_write (dec_rd_write),
        .imm      (dec_imm)
    );

    assign rf_read1_id = dec_rs1;
    assign rf_read2_id = dec_rs2;

    assign wb_hit_rs1 = wb_write_en && (wb_write_id == dec_rs1);
    assign wb_hit_rs2 = wb_write_en && (wb_write_id == dec_rs2);
    assign wb_hit_rd  = wb_write_en && (wb_write_id == dec_rd);

    // A same-cycle writeback both supplies the operand and retires the pending write.
    assign raw_stall = (dec_rs1_used && pending[dec_rs1] && !wb_hit_rs1)
                    || (dec_rs2_used && pending[dec_rs2] && !wb_hit_rs2);
    assign waw_stall = dec_rd_write && pending[dec_rd] && !wb_hit_rd;

    assign if_ready = (rst_n != RESET) && !flush && !raw_stall && !waw_stall
                   && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // The register file does not hardwire x0, so index 0 is forced to zero here.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (dec_rs1_used && dec_rs1 != '0) begin
            rs1_data = wb_hit_rs1 ? wb_write_data : rf_read1_data;
        end
        if (dec_rs2_used && dec_rs2 != '0) begin
            rs2_data = wb_hit_rs2 ? wb_write_data : rf_read2_data;
        end
    end

    // Clears are applied first so that a set on the same index in the same cycle wins.
    always_comb begin
        pending_next = pending;
        if (wb_write_en) begin
            pending_next[wb_write_id] = 1'b0;
        end
        if (sb_release) begin
            pending_next[sb_release_id] = 1'b0;
        end
        if (flush && ex_valid && ex_rd_write) begin
            pending_next[ex_rd] = 1'b0;
        end
        if (accept && dec_rd_write) begin
            pending_next[dec_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_n == RESET) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n == RESET) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_op       <= OP_ILLEGAL;
            ex_funct    <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rd_write <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_op       <= dec_op;
            ex_funct    <= dec_funct;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= dec_imm;
            ex_rd       <= dec_rd;
            ex_rd_write <= dec_rd_write;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
